eprom_prog_ctrl: RTL

Command sequencer that sits between a host and the 16x16 EPROM array. It turns single host commands (READ, WRITE, ERASE) into properly timed EPROM port activity:
- multi-cycle program pulses, with read-back verify and bounded retry;
- a timed erase pulse, followed by a blank-check scan.

The host sees one valid/ready command channel and one valid/ready response channel. The EPROM ports are owned exclusively by this block.

---
 rtl/eprom_prog_ctrl_if.sv | 24 ++
 rtl/eprom_prog_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/eprom_prog_ctrl_if.sv
// Host-side command and response channels of the EPROM program controller.
// The host drives the command channel and accepts the response channel.
interface eprom_prog_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  rsp_tries;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_tries
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_tries
  );
endinterface

// File: rtl/eprom_prog_ctrl.sv
// EPROM command sequencer: turns host READ/WRITE/ERASE commands into timed
// EPROM port activity (program pulses with verify/retry, erase + blank check).
//
// state  | meaning
// IDLE   | waiting for a host command, cmd_ready high
// READ   | one cycle presenting the address, data captured at its end
// PROG   | program pulse, mem_we held for PULSE_CYCLES cycles
// VERIFY | one cycle read-back compare against the write data
// ERASE  | erase pulse, mem_erase held for ERASE_CYCLES cycles
// BLANK  | scan all 16 words, counting non-zero ones
// RESP   | response presented until the host accepts it
module eprom_prog_ctrl #(
  parameter int PULSE_CYCLES = 4,
  parameter int MAX_TRIES    = 3,
  parameter int ERASE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  eprom_prog_ctrl_if.slave     bus,
  output logic [3:0]           mem_addr,
  output logic                 mem_we,
  output logic [15:0]          mem_wdata,
  output logic                 mem_erase,
  input  logic [15:0]          mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_PROG, S_VERIFY, S_ERASE, S_BLANK, S_RESP
  } state_t;

  localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] TRIES_MAX  = 4'(MAX_TRIES);
  localparam logic [7:0] ERASE_LOAD = 8'(ERASE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  addr_q;
  logic [3:0]  tries_q;
  logic [3:0]  pulse_cnt;
  logic [7:0]  erase_cnt;
  logic [4:0]  blank_cnt;
  logic [4:0]  blank_sum;
  logic        verify_ok;
  logic [15:0] rsp_data_q;
  logic        rsp_err_q;

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_tries = tries_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode plus the read-back compare and blank-count adder.
  always_comb begin
    state_nxt = state;
    verify_ok = (mem_rdata == mem_wdata);
    blank_sum = blank_cnt + {4'd0, |mem_rdata};
    case (state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            2'b00:   state_nxt = S_READ;
            2'b01:   state_nxt = S_PROG;
            2'b10:   state_nxt = S_ERASE;
            default: state_nxt = S_RESP;
          endcase
        end
      end
      S_READ:   state_nxt = S_RESP;
      S_PROG:   if (pulse_cnt == 4'd0) state_nxt = S_VERIFY;
      S_VERIFY: begin
        if (verify_ok)                state_nxt = S_RESP;
        else if (tries_q < TRIES_MAX) state_nxt = S_PROG;
        else                          state_nxt = S_RESP;
      end
      S_ERASE:  if (erase_cnt == 8'd0) state_nxt = S_BLANK;
      S_BLANK:  if (mem_addr == 4'hF) state_nxt = S_RESP;
      S_RESP:   if (bus.rsp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: command latch, pulse timers, scan counter, response capture.
  // mem_we/mem_erase follow the next state so they are registered and
  // mutually exclusive by construction.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= 4'd0;
      tries_q    <= 4'd0;
      pulse_cnt  <= 4'd0;
      erase_cnt  <= 8'd0;
      blank_cnt  <= 5'd0;
      rsp_data_q <= 16'd0;
      rsp_err_q  <= 1'b0;
      mem_addr   <= 4'd0;
      mem_wdata  <= 16'd0;
      mem_we     <= 1'b0;
      mem_erase  <= 1'b0;
    end else begin
      mem_we    <= (state_nxt == S_PROG);
      mem_erase <= (state_nxt == S_ERASE);
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            addr_q   <= bus.cmd_addr;
            mem_addr <= bus.cmd_addr;
            tries_q  <= 4'd0;
            case (bus.cmd_op)
              2'b01: begin
                mem_wdata <= bus.cmd_wdata;
                tries_q   <= 4'd1;
                pulse_cnt <= PULSE_LOAD;
              end
              2'b10: erase_cnt <= ERASE_LOAD;
              2'b11: begin
                rsp_data_q <= 16'd0;
                rsp_err_q  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_READ: begin
          rsp_data_q <= mem_rdata;
          rsp_err_q  <= 1'b0;
        end
        S_PROG: begin
          if (pulse_cnt != 4'd0) pulse_cnt <= pulse_cnt - 4'd1;
        end
        S_VERIFY: begin
          if (state_nxt == S_PROG) begin
            pulse_cnt <= PULSE_LOAD;
            if (tries_q != TRIES_MAX) tries_q <= tries_q + 4'd1;
          end else begin
            rsp_data_q <= mem_rdata;
            rsp_err_q  <= !verify_ok;
          end
        end
        S_ERASE: begin
          if (erase_cnt != 8'd0) begin
            erase_cnt <= erase_cnt - 8'd1;
          end else begin
            mem_addr  <= 4'd0;
            blank_cnt <= 5'd0;
          end
        end
        S_BLANK: begin
          if (mem_addr == 4'hF) begin
            rsp_data_q <= {11'd0, blank_sum};
            rsp_err_q  <= (blank_sum != 5'd0);
            mem_addr   <= addr_q;
          end else begin
            blank_cnt <= blank_sum;
            mem_addr  <= mem_addr + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
